// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Data-hazard scoreboard for a classic in-order pipeline. It tracks the
//   destination register and remaining "time to new value" (Tnew) of every
//   instruction in flight between E (entry 1) and W (entry DEPTH). For each
//   D-stage source port it picks a forwarding source or requests a stall.
//   It also models a multiply/divide unit busy counter that stalls MDU users
//   while a mult/div is in progress.
//
// Parameters:
//   NSRC    - number of D-stage source register ports
//   DEPTH   - number of tracked downstream stages (1 = E ... DEPTH = W)
//   TW      - width of Tuse/Tnew fields
//   MUL_LAT - MDU busy cycles for mult
//   DIV_LAT - MDU busy cycles for div
//   FW      - forward-select width, $clog2(DEPTH+1) (derived)
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   valid_D     in   D-stage instruction is real
//   src_addr_D  in   NSRC x 5-bit source register numbers
//   src_tuse_D  in   NSRC x TW-bit Tuse per source port
//   dst_addr_D  in   destination register, 0 = none
//   dst_tnew_D  in   Tnew of the D instruction at entry to E
//   md_start_D  in   D instruction is mult or div
//   md_div_D    in   qualifies md_start_D as div
//   md_use_D    in   D instruction is any MDU op
//   flush       in   kill all in-flight entries
//   fwd_sel_D   out  per port: 0 = register file, k = forward from entry k
//   stall       out  freeze F/D and insert a bubble into E
//   stall_cnt   out  number of stall cycles (saturating)
//
// Configuration:
//   HAZARD_STALL_CNT_EN - when defined, stall_cnt is a live saturating
//   counter; otherwise stall_cnt is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NSRC    = 2,
    parameter int DEPTH   = 3,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int FW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_D,
    input  logic [NSRC*5-1:0]    src_addr_D,
    input  logic [NSRC*TW-1:0]   src_tuse_D,
    input  logic [4:0]           dst_addr_D,
    input  logic [TW-1:0]        dst_tnew_D,
    input  logic                 md_start_D,
    input  logic                 md_div_D,
    input  logic                 md_use_D,
    input  logic                 flush,
    output logic [NSRC*FW-1:0]   fwd_sel_D,
    output logic                 stall,
    output logic [31:0]          stall_cnt
);

    localparam int CW = $clog2(DIV_LAT + 1);

    // Pipeline entries; bit/element 0 holds entry 1 (E).
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0][4:0]     dst_q,   dst_d;
    logic [DEPTH-1:0][TW-1:0]  tnew_q,  tnew_d;

    logic [CW-1:0]             md_cnt_q, md_cnt_d;
    logic                      md_busy;
    logic                      md_stall;
    logic [NSRC-1:0]           port_stall;

    // -----------------------------------------------------------------------
    // Per-port hazard detection (purely combinational, zero-cycle latency)
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < NSRC; gi++) begin : g_port
        logic [4:0]    addr;
        logic [TW-1:0] tuse;
        logic          hit;
        logic [FW-1:0] hit_idx;
        logic [TW-1:0] hit_tnew;

        assign addr = src_addr_D[gi*5 +: 5];
        assign tuse = src_tuse_D[gi*TW +: TW];

        // Scan oldest to youngest so the youngest (lowest-index) match is
        // the one left standing; older writers of the same register are
        // shadowed by it.
        always_comb begin
            hit      = 1'b0;
            hit_idx  = '0;
            hit_tnew = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (addr != 5'd0 && valid_q[k] && dst_q[k] == addr) begin
                    hit      = 1'b1;
                    hit_idx  = FW'(k + 1);
                    hit_tnew = tnew_q[k];
                end
            end
        end

        assign port_stall[gi]          = hit && (hit_tnew > tuse);
        assign fwd_sel_D[gi*FW +: FW]  = (!reset && hit && hit_tnew == '0) ? hit_idx : '0;
    end

    // -----------------------------------------------------------------------
    // MDU busy tracking
    // -----------------------------------------------------------------------
    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = valid_D && md_use_D && md_busy;

    assign stall = valid_D && !flush && !reset && ((|port_stall) || md_stall);

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (valid_D && md_start_D && !stall) begin
            md_cnt_d = md_div_D ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            // A flush does not cancel an MDU operation already in progress.
            md_cnt_q <= md_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry shift: D -> E -> ... -> W, Tnew counts down to zero. The
    // old contents of the last entry simply fall off the end.
    // -----------------------------------------------------------------------
    always_comb begin
        // A stalled D instruction enters E as a bubble.
        valid_d[0] = valid_D && !stall && (dst_addr_D != 5'd0);
        dst_d[0]   = dst_addr_D;
        tnew_d[0]  = dst_tnew_D;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            dst_d[k]   = dst_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            dst_q   <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            tnew_q  <= tnew_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional stall statistics
    // -----------------------------------------------------------------------
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard with default parameters.
// A behavioural reference model predicts fwd_sel_D / stall / stall_cnt for
// every cycle; predictions are queued when inputs are driven and popped on
// the falling edge when the DUT outputs are sampled. Directed scenarios add
// constant-valued checks on the sampled DUT outputs.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int TW    = 3;
    localparam int FW    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_D;
    logic [NSRC*5-1:0]    src_addr_D;
    logic [NSRC*TW-1:0]   src_tuse_D;
    logic [4:0]           dst_addr_D;
    logic [TW-1:0]        dst_tnew_D;
    logic                 md_start_D;
    logic                 md_div_D;
    logic                 md_use_D;
    logic                 flush;
    logic [NSRC*FW-1:0]   fwd_sel_D;
    logic                 stall;
    logic [31:0]          stall_cnt;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .valid_D    (valid_D),
        .src_addr_D (src_addr_D),
        .src_tuse_D (src_tuse_D),
        .dst_addr_D (dst_addr_D),
        .dst_tnew_D (dst_tnew_D),
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .md_use_D   (md_use_D),
        .flush      (flush),
        .fwd_sel_D  (fwd_sel_D),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NSRC*FW-1:0] fwd;
        logic               stl;
        logic [31:0]        cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (entry index 1 = E)
    logic        m_valid [1:DEPTH];
    logic [4:0]  m_dst   [1:DEPTH];
    int          m_tnew  [1:DEPTH];
    int          m_md;
    logic [31:0] m_scnt;

    // Last sampled DUT outputs
    logic [NSRC*FW-1:0] obs_fwd;
    logic               obs_stall;
    logic [31:0]        obs_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= DEPTH; k++) begin
            m_valid[k] = 1'b0;
            m_dst[k]   = 5'd0;
            m_tnew[k]  = 0;
        end
    endtask

    task automatic model_eval(output logic [NSRC*FW-1:0] fwd, output logic stl);
        logic req;
        req = 1'b0;
        fwd = '0;
        for (int p = 0; p < NSRC; p++) begin
            logic [4:0] a;
            int         tu;
            bit         found;
            a     = src_addr_D[p*5 +: 5];
            tu    = int'(src_tuse_D[p*TW +: TW]);
            found = 0;
            if (a != 5'd0) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    if (!found && m_valid[k] && m_dst[k] == a) begin
                        found = 1;
                        if (m_tnew[k] > tu) req = 1'b1;
                        if (m_tnew[k] == 0) fwd[p*FW +: FW] = FW'(k);
                    end
                end
            end
        end
        if (valid_D && md_use_D && m_md != 0) req = 1'b1;
        stl = req && valid_D && !flush && !reset;
        if (reset) fwd = '0;
    endtask

    task automatic model_update(input logic stl);
        if (reset) begin
            model_clear();
            m_md   = 0;
            m_scnt = 32'd0;
        end else begin
`ifdef HAZARD_STALL_CNT_EN
            if (stl && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
`endif
            if (flush) begin
                model_clear();
            end else begin
                for (int k = DEPTH; k >= 2; k--) begin
                    m_valid[k] = m_valid[k-1];
                    m_dst[k]   = m_dst[k-1];
                    m_tnew[k]  = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
                end
                m_valid[1] = valid_D && !stl && dst_addr_D != 5'd0;
                m_dst[1]   = dst_addr_D;
                m_tnew[1]  = int'(dst_tnew_D);
            end
            if (valid_D && md_start_D && !stl) m_md = md_div_D ? 10 : 5;
            else if (m_md > 0) m_md = m_md - 1;
        end
    endtask

    // One clock cycle: predict, sample on the falling edge, compare, advance.
    task automatic cycle();
        exp_t e;
        exp_t o;
        model_eval(e.fwd, e.stl);
        e.cnt = m_scnt;
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        obs_fwd   = fwd_sel_D;
        obs_stall = stall;
        obs_cnt   = stall_cnt;
        check_val("fwd_sel", 32'(obs_fwd), 32'(o.fwd));
        check_val("stall", 32'(obs_stall), 32'(o.stl));
        check_val("stall_cnt", obs_cnt, o.cnt);
        @(posedge clk);
        model_update(o.stl);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input int t0,
                         input logic [4:0] s1, input int t1,
                         input logic [4:0] d, input int tn,
                         input logic ms, input logic mdv, input logic mu, input logic fl);
        valid_D    = v;
        src_addr_D = {s1, s0};
        src_tuse_D = {3'(t1), 3'(t0)};
        dst_addr_D = d;
        dst_tnew_D = 3'(tn);
        md_start_D = ms;
        md_div_D   = mdv;
        md_use_D   = mu;
        flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        idle();
        model_clear();
        m_md   = 0;
        m_scnt = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset gating: a live match must not forward or stall under reset.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        reset = 1'b1;
        drive(1'b1, 5'd5, 0, 5'd5, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("rst_fwd", 32'(obs_fwd), 32'd0);
        check_val("rst_stall", 32'(obs_stall), 32'd0);
        check_val("rst_cnt", obs_cnt, 32'd0);
        reset = 1'b0;
        cycle();
        check_val("rst_cleared_fwd", 32'(obs_fwd), 32'd0);

        // Load-use: lw $5 (tnew 2), consumer tuse 0.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd5, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd5, 0, 5'd0, 0, 5'd6, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("lu_stall1", 32'(obs_stall), 32'd1);
        cycle();
        check_val("lu_stall2", 32'(obs_stall), 32'd1);
        cycle();
        check_val("lu_release", 32'(obs_stall), 32'd0);
        check_val("lu_fwd", 32'(obs_fwd), 32'd3);

        // ALU chain: addu $3 (tnew 1), consumer tuse 1, then tuse 0.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("alu_nostall", 32'(obs_stall), 32'd0);
        check_val("alu_fwd_e", 32'(obs_fwd), 32'd0);
        drive(1'b1, 5'd0, 0, 5'd3, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("alu_fwd_m_p1", 32'(obs_fwd), 32'(2'd2 << FW));

        // Double match: youngest writer of $7 (tnew 0) wins.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd7, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("dbl_fwd", 32'(obs_fwd), 32'd1);
        check_val("dbl_stall", 32'(obs_stall), 32'd0);

        // Register $0 never forwards.
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("r0_fwd", 32'(obs_fwd), 32'd0);
        check_val("r0_stall", 32'(obs_stall), 32'd0);

        // Bubble: a stalled instruction's dst must not be matched.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd9, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd9, 0, 5'd0, 0, 5'd10, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("bub_stall", 32'(obs_stall), 32'd1);
        drive(1'b1, 5'd9, 1, 5'd10, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("bub_nostall", 32'(obs_stall), 32'd0);

        // MDU: div then mfhi.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (obs_stall) n++;
            else break;
        end
        check_val("div_stalls", 32'(n), 32'd10);
`ifdef HAZARD_STALL_CNT_EN
        check_val("div_scnt", obs_cnt, 32'd10);
`else
        check_val("div_scnt", obs_cnt, 32'd0);
`endif

        // Mult then mflo.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (obs_stall) n++;
            else break;
        end
        check_val("mul_stalls", 32'(n), 32'd5);

        // Flush during a load-use stall with a mult in progress.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        check_val("flush_stall", 32'(obs_stall), 32'd0);
        drive(1'b1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("flush_clr_stall", 32'(obs_stall), 32'd0);
        check_val("flush_clr_fwd", 32'(obs_fwd), 32'd0);
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (obs_stall) n++;
            else break;
        end
        check_val("flush_mdcnt", 32'(n), 32'd2);

        // Reset aborts an MDU operation.
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        idle();
        cycle();
        rst_cycle();
        drive(1'b1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("rst_md_abort", 32'(obs_stall), 32'd0);

        // Random traffic against the model.
        rst_cycle();
        for (int i = 0; i < 400; i++) begin
            logic ms;
            ms = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  5'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  5'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  ms, 1'($urandom_range(0, 1)),
                  ms || ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
